// File: rtl/spi_cmd_tx.sv
// SPI command transmitter: serialises display commands as CS-framed byte sequences, MSB first.
// Optional macro SPI_CMD_TX_BURST_EN lets a WriteChar accepted during TAIL extend the current frame.
module spi_cmd_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned TAIL    = 4
) (
  input  logic        PixClk5,
  input  logic        nReset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [2:0]  CmdOp,
  input  logic [11:0] CmdAddr,
  input  logic [1:0]  CmdBlink,
  input  logic [7:0]  CmdColor,
  input  logic [7:0]  CmdChar,
  input  logic [11:0] CmdSize,
  output logic        SPI_CLK,
  output logic        SPI_MOSI,
  output logic        SPI_CS,
  output logic        Busy
);

  localparam logic [11:0] DivM1  = 12'(CLK_DIV - 1);
  localparam logic [11:0] TailM1 = 12'(TAIL - 1);
  localparam bit          GapEn  = (CS_GAP >= 2);
  // The IDLE cycle that accepts the next command completes the CS-low gap.
  localparam logic [11:0] GapM2  = GapEn ? 12'(CS_GAP - 2) : 12'd0;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StBitHigh,
    StBitLow,
    StTail,
    StCsGap
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  bytes_q, bytes_d;
  logic [47:0] sr_q, sr_d;
  logic        ext_q, ext_d;
  logic [11:0] size_q, size_d;
  logic        rdy_q, rdy_d;

  logic [47:0] load_sr;
  logic [2:0]  load_n;
  logic        op_ok;
  logic        accept;

`ifdef SPI_CMD_TX_BURST_EN
  logic wc_q, wc_d;
  logic tail_wc_q, tail_wc_d;
  assign CmdReady = rdy_q | (tail_wc_q & (CmdOp == 3'd2));
`else
  assign CmdReady = rdy_q;
`endif

  assign accept = CmdValid & CmdReady;

  // Frame image, left-aligned so the first byte leaves from bit 47.
  always_comb begin
    load_sr = '0;
    load_n  = '0;
    op_ok   = 1'b1;
    case (CmdOp)
      3'd0: begin
        load_sr = {8'h82, 4'h0, CmdAddr[11:8], CmdAddr[7:0], 24'h0};
        load_n  = 3'd3;
      end
      3'd1: begin
        load_sr = {8'h83, 6'h0, CmdBlink, CmdColor, 24'h0};
        load_n  = 3'd3;
      end
      3'd2: begin
        load_sr = {8'h81, CmdChar, 32'h0};
        load_n  = 3'd2;
      end
      3'd3: begin
        load_sr = {8'h84, 4'h0, CmdSize[11:8], CmdSize[7:0], CmdChar, 16'h0};
        load_n  = 3'd4;
      end
      3'd4: begin
        load_sr = {8'h80, 4'h0, CmdAddr[11:8], CmdAddr[7:0], 6'h0, CmdBlink, CmdColor, CmdChar};
        load_n  = 3'd6;
      end
      default: op_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    bytes_d = bytes_q;
    sr_d    = sr_q;
    ext_d   = ext_q;
    size_d  = size_q;
`ifdef SPI_CMD_TX_BURST_EN
    wc_d    = wc_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept && op_ok) begin
          state_d = StCsSetup;
          cnt_d   = DivM1;
          sr_d    = load_sr;
          bytes_d = load_n;
          bit_d   = 3'd7;
          ext_d   = (CmdOp == 3'd3) && (CmdSize != 12'd0);
          size_d  = CmdSize;
`ifdef SPI_CMD_TX_BURST_EN
          wc_d    = (CmdOp == 3'd2);
`endif
        end
      end
      StCsSetup: begin
        if (cnt_q == 12'd0) begin
          state_d = StBitHigh;
          cnt_d   = DivM1;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      StBitHigh: begin
        if (cnt_q == 12'd0) begin
          state_d = StBitLow;
          cnt_d   = DivM1;
          sr_d    = {sr_q[46:0], 1'b0};
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      StBitLow: begin
        if (cnt_q == 12'd0) begin
          cnt_d   = DivM1;
          state_d = StBitHigh;
          if (bit_q != 3'd0) begin
            bit_d = bit_q - 3'd1;
          end else begin
            bit_d = 3'd7;
            if (bytes_q == 3'd1) begin
              state_d = StTail;
              cnt_d   = TailM1;
              bytes_d = 3'd0;
            end else begin
              bytes_d = bytes_q - 3'd1;
            end
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      StTail: begin
        if (cnt_q != 12'd0) begin
          cnt_d = cnt_q - 12'd1;
        end else if (ext_q) begin
          // Repeat extension runs as a second pass so the counter never exceeds 12 bits.
          ext_d = 1'b0;
          cnt_d = size_q - 12'd1;
        end else if (GapEn) begin
          state_d = StCsGap;
          cnt_d   = GapM2;
        end else begin
          state_d = StIdle;
        end
`ifdef SPI_CMD_TX_BURST_EN
        if (accept) begin
          state_d = StCsSetup;
          cnt_d   = DivM1;
          sr_d    = {CmdChar, 40'h0};
          bytes_d = 3'd1;
          bit_d   = 3'd7;
          ext_d   = 1'b0;
        end
`endif
      end
      StCsGap: begin
        if (cnt_q == 12'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    rdy_d = (state_d == StIdle);
`ifdef SPI_CMD_TX_BURST_EN
    tail_wc_d = (state_d == StTail) && wc_d;
`endif
  end

  always_ff @(posedge PixClk5) begin
    if (!nReset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      bytes_q   <= '0;
      sr_q      <= '0;
      ext_q     <= 1'b0;
      size_q    <= '0;
      rdy_q     <= 1'b0;
`ifdef SPI_CMD_TX_BURST_EN
      wc_q      <= 1'b0;
      tail_wc_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      bytes_q   <= bytes_d;
      sr_q      <= sr_d;
      ext_q     <= ext_d;
      size_q    <= size_d;
      rdy_q     <= rdy_d;
`ifdef SPI_CMD_TX_BURST_EN
      wc_q      <= wc_d;
      tail_wc_q <= tail_wc_d;
`endif
    end
  end

  assign SPI_CS   = (state_q == StCsSetup) || (state_q == StBitHigh) ||
                    (state_q == StBitLow)  || (state_q == StTail);
  assign SPI_CLK  = (state_q == StBitHigh);
  assign SPI_MOSI = SPI_CS & sr_q[47];
  assign Busy     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_cmd_tx.sv
// Scoreboard bench for spi_cmd_tx: driver queues expected frames, SPI monitor decodes and compares.
module tb_spi_cmd_tx;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 4;
  localparam int TAIL    = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  op = '0;
  logic [11:0] addr = '0;
  logic [1:0]  blink = '0;
  logic [7:0]  color = '0;
  logic [7:0]  ch = '0;
  logic [11:0] size = '0;
  logic        ready, sclk, mosi, cs, busy;

  always #5 clk = ~clk;

  spi_cmd_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .TAIL(TAIL)) dut (
    .PixClk5(clk), .nReset(nrst), .CmdValid(valid), .CmdReady(ready), .CmdOp(op),
    .CmdAddr(addr), .CmdBlink(blink), .CmdColor(color), .CmdChar(ch), .CmdSize(size),
    .SPI_CLK(sclk), .SPI_MOSI(mosi), .SPI_CS(cs), .Busy(busy)
  );

  typedef struct {
    logic [7:0]  b [32];
    int          n;
    int          len;
    int          wr_cnt;
    bit          chk_wr_ad;
    logic [11:0] wr_addr;
    logic [17:0] wr_data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: byte list, frame length and receiver cell writes from the command alone.
  function automatic exp_t model(input int o, input int a, input int bl, input int co,
                                 input int c, input int s);
    exp_t e;
    for (int i = 0; i < 32; i++) e.b[i] = 8'h00;
    e.n = 0; e.wr_cnt = 0; e.chk_wr_ad = 0; e.wr_addr = '0; e.wr_data = '0;
    case (o)
      0: begin e.b[0] = 8'h82; e.b[1] = 8'(a / 256); e.b[2] = 8'(a % 256); e.n = 3; end
      1: begin e.b[0] = 8'h83; e.b[1] = 8'(bl); e.b[2] = 8'(co); e.n = 3; end
      2: begin e.b[0] = 8'h81; e.b[1] = 8'(c); e.n = 2; e.wr_cnt = 1; end
      3: begin
        e.b[0] = 8'h84; e.b[1] = 8'(s / 256); e.b[2] = 8'(s % 256); e.b[3] = 8'(c);
        e.n = 4; e.wr_cnt = s + 1;
      end
      default: begin
        e.b[0] = 8'h80; e.b[1] = 8'(a / 256); e.b[2] = 8'(a % 256);
        e.b[3] = 8'(bl); e.b[4] = 8'(co); e.b[5] = 8'(c); e.n = 6;
        e.wr_cnt = 1; e.chk_wr_ad = 1; e.wr_addr = 12'(a);
        e.wr_data = 18'(bl * 65536 + co * 256 + c);
      end
    endcase
    e.len = CLK_DIV * (1 + 16 * e.n) + TAIL + ((o == 3) ? s : 0);
    return e;
  endfunction

  task automatic send(input int o, input int a, input int bl, input int co, input int c,
                      input int s);
    exp_t e;
    int t = 0;
    bit got = 0;
    @(posedge clk); #1;
    op = 3'(o); addr = 12'(a); blink = 2'(bl); color = 8'(co); ch = 8'(c); size = 12'(s);
    valid = 1'b1;
    while (!got && t < 20000) begin
      @(negedge clk);
      if (ready === 1'b1) got = 1; else t++;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
    end else if (o < 5) begin
      e = model(o, a, bl, co, c, s);
`ifdef SPI_CMD_TX_BURST_EN
      if (o == 2 && sb.size() > 0 && sb[$].b[0] == 8'h81 && sb[$].n < 32) begin
        exp_t m;
        m = sb.pop_back();
        m.b[m.n] = 8'(c); m.n++; m.len = -1; m.wr_cnt++;
        sb.push_back(m);
      end else begin
        sb.push_back(e); exp_frames++;
      end
`else
      sb.push_back(e); exp_frames++;
`endif
    end
    @(posedge clk); #1;
    valid = 1'b0;
    op = 3'($urandom); addr = 12'($urandom); blink = 2'($urandom);
    color = 8'($urandom); ch = 8'($urandom); size = 12'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 30000) begin
      @(negedge clk); t++;
    end
    if (t >= 30000) chk("idle_timeout", 0, 1);
  endtask

  // SPI monitor
  bit         pcs = 0, pclk = 0, pmosi = 0, in_frame = 0, gap_valid = 0;
  int         flen, hrun, lrun, rises, rxn, bitn, gap = 0, last_gap = 0, frames = 0;
  logic [7:0] acc;
  logic [7:0] rx [32];

  task automatic end_frame();
    exp_t e;
    int wc = 0;
    logic [11:0] wa = '0;
    logic [17:0] wd = '0;
    if (sb.size() == 0) begin
      chk("unexpected_frame", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("byte_count", rxn, e.n);
    chk("bit_residue", bitn, 0);
    for (int i = 0; i < e.n && i < 32 && i < rxn; i++) chk($sformatf("byte%0d", i), rx[i], e.b[i]);
    chk("rising_edges", rises, 8 * e.n);
    if (e.len >= 0) chk("frame_len", flen, e.len);
    if (rxn >= 1) begin
      case (rx[0])
        8'h80: if (rxn == 6) begin
          wc = 1; wa = {rx[1][3:0], rx[2]}; wd = {rx[3][1:0], rx[4], rx[5]};
        end
        8'h84: if (rxn == 4) wc = int'({rx[1][3:0], rx[2]}) + 1;
        8'h81: wc = rxn - 1;
        default: wc = 0;
      endcase
    end
    chk("wr_count", wc, e.wr_cnt);
    if (e.chk_wr_ad) begin
      chk("wr_addr", wa, e.wr_addr);
      chk("wr_data", wd, e.wr_data);
    end
  endtask

  always @(negedge clk) begin
    if (!nrst) begin
      in_frame = 0; gap_valid = 0; gap = 0;
    end else begin
      if (!cs) begin
        chk("idle_clk", sclk, 0);
        chk("idle_mosi", mosi, 0);
      end
      if (cs || sclk) chk("busy_in_frame", busy, 1);
`ifndef SPI_CMD_TX_BURST_EN
      if (ready) chk("ready_only_idle", busy, 0);
`endif
      if (cs && !pcs) begin
        if (gap_valid) chk("cs_gap_min", (gap >= CS_GAP), 1);
        last_gap = gap;
        in_frame = 1; flen = 0; hrun = 0; lrun = 0; rises = 0; rxn = 0; bitn = 0; acc = '0;
      end
      if (in_frame && cs) begin
        flen++;
        if (sclk && !pclk) begin
`ifndef SPI_CMD_TX_BURST_EN
          chk("low_half", lrun, CLK_DIV);
`endif
          rises++;
          acc = {acc[6:0], mosi};
          bitn++;
          if (bitn == 8) begin
            if (rxn < 32) rx[rxn] = acc;
            rxn++; bitn = 0;
          end
          lrun = 0;
        end
        if (!sclk && pclk) begin
          chk("high_half", hrun, CLK_DIV);
          hrun = 0;
        end
        if (sclk && pcs && mosi !== pmosi) chk("mosi_stable_clk_high", 0, 1);
        if (sclk) hrun++; else lrun++;
      end
      if (in_frame && !cs && pcs) begin
        in_frame = 0; frames++; gap = 0; gap_valid = 1;
        end_frame();
      end
      if (!cs) gap++;
    end
    pcs = cs; pclk = sclk; pmosi = mosi;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int act;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", cs, 0); chk("rst_clk", sclk, 0); chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0); chk("rst_ready", ready, 0);
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ready_after_release", ready, 1);

    send(0, 'h123, 0, 0, 0, 0);
    wait_idle();
    chk("ready_after_setloc", ready, 1);

    send(4, 'hABC, 2, 'h1F, 'h41, 0);
    wait_idle();

    send(3, 0, 0, 0, 'h20, 'h00A);
    wait_idle();

    // Abort WriteRaw partway through its third byte.
    send(4, 'h5A5, 1, 'h33, 'h77, 0);
    repeat (CLK_DIV + 16 * CLK_DIV * 2 + 8) @(posedge clk);
    #1 nrst = 1'b0;
    exp_frames -= sb.size();
    sb.delete();
    @(posedge clk); @(negedge clk);
    chk("abort_cs", cs, 0); chk("abort_clk", sclk, 0); chk("abort_mosi", mosi, 0);
    chk("abort_busy", busy, 0); chk("abort_ready", ready, 0);
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ready_after_abort", ready, 1);
    send(1, 0, 1, 'hF0, 0, 0);
    wait_idle();

    send(2, 0, 0, 0, 'h48, 0);
    send(2, 0, 0, 0, 'h49, 0);
    wait_idle();
`ifndef SPI_CMD_TX_BURST_EN
    chk("b2b_gap", last_gap, CS_GAP);
`endif

    send(6, 'h111, 1, 2, 3, 4);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (cs || busy) act++;
    end
    chk("reserved_no_activity", act, 0);
    chk("reserved_ready", ready, 1);

    repeat (16) begin
      send($urandom_range(0, 7), $urandom_range(0, 4095), $urandom_range(0, 3),
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 40));
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    wait_idle();

    send(3, 0, 0, 0, 'h55, 'hFFF);
    wait_idle();

    chk("scoreboard_empty", sb.size(), 0);
    chk("frames_seen", frames, exp_frames);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
